mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Memory-side responder for the CPU's byte-serial memory port. It answers each single-byte access presented by the cache/memory controller, one access per cycle. Accesses go to a synchronous byte RAM, or to a small memory-mapped I/O window that buffers bytes to and from a host link. It also raises the almost-full stall and simulation-end indications the core needs.

## Interface
Parameters:
- RAM_ADDR_WIDTH, 17: RAM holds 2**RAM_ADDR_WIDTH bytes, indexed by addrIn[RAM_ADDR_WIDTH-1:0].
- FIFO_DEPTH_LOG, 3: each I/O FIFO holds 2**FIFO_DEPTH_LOG bytes.

Ports:
- clkIn  in  1  system clock; one clock, all state on its rising edge.
- resetIn  in  1  reset, synchronous, active-high.
- readWriteIn  in  1  access direction from initiator; read 0, write 1.
- addrIn  in  32  byte address of current access.
- dataIn  in  8  write byte.
- dataOut  out  8  read byte, registered.
- ioOutValid  out  1  head of output FIFO is valid.
- ioOutData  out  8  head byte of output FIFO (show-ahead).
- ioOutReady  in  1  host accepts head byte.
- ioInValid  in  1  host offers a byte.
- ioInData  in  8  offered byte.
- ioInReady  out  1  input FIFO can accept a byte.
- ioBufferFull  out  1  output FIFO almost full; the core must stop issuing I/O writes.
- simEnd  out  1  sticky program-end flag.

## Operation
- Decode:
  - addrIn[17:16]==2'b11 selects I/O.
  - Any other address selects RAM at addrIn[RAM_ADDR_WIDTH-1:0]; upper bits are ignored.
- Every cycle is an access; there is no valid strobe. An idle initiator parks on read of address 0, which must have no side effect.
- RAM read: dataOut <= ram[index].
- RAM write: ram[index] <= dataIn, and dataOut <= 0.
- RAM contents are not cleared by reset.
- I/O map, low 3 bits (addrIn[2:0]); other I/O addresses read 0 and ignore writes:
  - 0x30000 write: push dataIn into the output FIFO. If the FIFO is full, the byte is dropped.
  - 0x30000 read: pop the input FIFO and return its head byte. If the FIFO is empty, return 0 and pop nothing.
  - 0x30004 write: set the end-request latch. dataIn is ignored.
  - 0x30004 read: return {6'b0, outFull, inNonEmpty}. No side effect.
- Output FIFO:
  - Push from I/O writes; pop when ioOutValid && ioOutReady.
  - Simultaneous push and pop is legal at any count, including full; a push while full with a pop in the same cycle succeeds.
- Input FIFO:
  - Push when ioInValid && ioInReady.
  - ioInReady = !inFull, combinational from the count.
  - Simultaneous push and pop is legal.
- ioBufferFull = outCount >= 2**FIFO_DEPTH_LOG - 2. This leaves two slots of slack, because a multi-byte store cannot be stalled mid-transfer.
- simEnd rises the first cycle in which the end-request latch is set and the output FIFO is empty; it then stays high until reset.
- Pointers are FIFO_DEPTH_LOG bits wide and wrap modulo depth. Counts are FIFO_DEPTH_LOG+1 bits wide.

## Timing
- Read latency is 1 cycle: an address presented in cycle N drives dataOut in cycle N+1. This matches the initiator sampling memIn one cycle after issuing memAddr.
- Back-to-back reads of consecutive addresses stream one byte per cycle.
- Write in cycle N, then read of the same address in cycle N+1: dataOut in N+2 shows the new byte.
- An I/O pop takes effect at the same edge that registers dataOut.
- A host byte pushed at edge N is poppable by a read presented in cycle N+1.
- ioOutValid, ioBufferFull and ioInReady reflect the post-edge counts; they are combinational from registered counts.
- Reset values: dataOut 0, ioOutValid 0, ioOutData don't-care (0 preferred), ioInReady 1, ioBufferFull 0, simEnd 0.
- Reset empties both FIFOs and clears the end-request latch.
- Reset asserted mid-stream aborts any access in that cycle: no RAM write, no push, no pop.

## Test plan
- RAM round trip: write 0xA5 to 0x00010 and 0x3C to 0x00011, then read both back-to-back -> dataOut is 0xA5 then 0x3C on consecutive cycles, one cycle after each address.
- Idle parking: hold read of address 0 for 10 cycles with the input FIFO holding one byte -> dataOut = ram[0] throughout, and the input FIFO count stays 1.
- Output backpressure, depth 8: with ioOutReady=0, write bytes 0x41..0x48 to 0x30000 -> ioBufferFull rises after the 6th push, outFull after the 8th, and a 9th write of 0x49 is dropped. Then raise ioOutReady -> ioOutData presents 0x41..0x48 in order.
- Input path and wrap: host pushes 20 bytes 0x00..0x13 interleaved with CPU reads of 0x30000 (one per cycle) -> reads return the bytes in order across pointer wrap. A read while empty returns 0; status read at 0x30004 returns 0x01 when non-empty.
- End of program: with 3 bytes queued and ioOutReady=0, write 0x30004 -> simEnd stays 0. Raise ioOutReady -> simEnd rises the cycle after the FIFO empties and stays 1 until resetIn.
- Reset mid-operation: assert resetIn during a 0x30000 write with ioOutReady=1 and the output FIFO non-empty -> next cycle ioOutValid=0, ioBufferFull=0, simEnd=0, dataOut=0, and the written byte never appears on ioOutData.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// Byte-serial memory port plus host-link byte streams seen by the memory-side responder.
interface mem_io_responder_if;
  logic        readWriteIn;
  logic [31:0] addrIn;
  logic [7:0]  dataIn;
  logic [7:0]  dataOut;
  logic        ioOutValid;
  logic [7:0]  ioOutData;
  logic        ioOutReady;
  logic        ioInValid;
  logic [7:0]  ioInData;
  logic        ioInReady;
  logic        ioBufferFull;
  logic        simEnd;

  modport slave (
    input  readWriteIn, addrIn, dataIn, ioOutReady, ioInValid, ioInData,
    output dataOut, ioOutValid, ioOutData, ioInReady, ioBufferFull, simEnd
  );

  modport master (
    output readWriteIn, addrIn, dataIn, ioOutReady, ioInValid, ioInData,
    input  dataOut, ioOutValid, ioOutData, ioInReady, ioBufferFull, simEnd
  );
endinterface

// File: rtl/mem_io_responder.sv
// Answers one byte access per cycle from a synchronous RAM or a small I/O window
// that buffers bytes to/from the host link; also flags almost-full and program end.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH_LOG = 3
) (
  input logic               clkIn,
  input logic               resetIn,
  mem_io_responder_if.slave bus
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG;
  localparam int PTR_W = FIFO_DEPTH_LOG;
  localparam int CNT_W = FIFO_DEPTH_LOG + 1;
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 2);
  localparam logic [2:0]       REG_DATA   = 3'd0;
  localparam logic [2:0]       REG_CTRL   = 3'd4;

  logic [7:0] ram [2 ** RAM_ADDR_WIDTH];
  logic [7:0] outMem [DEPTH];
  logic [7:0] inMem [DEPTH];

  logic [PTR_W-1:0] outWrPtr, outRdPtr, inWrPtr, inRdPtr;
  logic [CNT_W-1:0] outCount, inCount;
  logic             endReq, simEndQ;
  logic [7:0]       dataOutQ, ioReadByte;

  logic                      isIo, ioData, ioCtrl, ramRead, ramWrite;
  logic                      outFull, outEmpty, inFull, inEmpty;
  logic                      outPush, outPop, inPush, inPop, endSet;
  logic [RAM_ADDR_WIDTH-1:0] ramIdx;
  logic                      unusedAddr;

  assign isIo     = bus.addrIn[17:16] == 2'b11;
  assign ioData   = isIo && (bus.addrIn[2:0] == REG_DATA);
  assign ioCtrl   = isIo && (bus.addrIn[2:0] == REG_CTRL);
  assign ramIdx   = bus.addrIn[RAM_ADDR_WIDTH-1:0];
  assign ramRead  = !isIo && !bus.readWriteIn;
  assign ramWrite = !isIo && bus.readWriteIn && !resetIn;
  assign unusedAddr = ^bus.addrIn;

  assign outFull  = outCount == CNT_FULL;
  assign outEmpty = outCount == '0;
  assign inFull   = inCount == CNT_FULL;
  assign inEmpty  = inCount == '0;

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign outPop  = !outEmpty && bus.ioOutReady;
  assign outPush = ioData && bus.readWriteIn && (!outFull || outPop);
  assign inPush  = bus.ioInValid && !inFull;
  assign inPop   = ioData && !bus.readWriteIn && !inEmpty;
  assign endSet  = ioCtrl && bus.readWriteIn;

  always_comb begin
    ioReadByte = 8'h00;
    if (!bus.readWriteIn) begin
      if (ioData && !inEmpty) ioReadByte = inMem[inRdPtr];
      else if (ioCtrl)        ioReadByte = {6'b0, outFull, !inEmpty};
    end
  end

  always_ff @(posedge clkIn) begin
    if (ramWrite) ram[ramIdx] <= bus.dataIn;
  end

  always_ff @(posedge clkIn) begin
    if (resetIn)      dataOutQ <= 8'h00;
    else if (ramRead) dataOutQ <= ram[ramIdx];
    else              dataOutQ <= ioReadByte;
  end

  always_ff @(posedge clkIn) begin
    if (!resetIn && outPush) outMem[outWrPtr] <= bus.dataIn;
    if (!resetIn && inPush)  inMem[inWrPtr]   <= bus.ioInData;
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      outWrPtr <= '0;
      outRdPtr <= '0;
      outCount <= '0;
      inWrPtr  <= '0;
      inRdPtr  <= '0;
      inCount  <= '0;
      endReq   <= 1'b0;
      simEndQ  <= 1'b0;
    end else begin
      if (outPush) outWrPtr <= outWrPtr + PTR_ONE;
      if (outPop)  outRdPtr <= outRdPtr + PTR_ONE;
      outCount <= outCount + CNT_W'(outPush) - CNT_W'(outPop);
      if (inPush) inWrPtr <= inWrPtr + PTR_ONE;
      if (inPop)  inRdPtr <= inRdPtr + PTR_ONE;
      inCount <= inCount + CNT_W'(inPush) - CNT_W'(inPop);
      if (endSet) endReq <= 1'b1;
      if (endReq && outEmpty) simEndQ <= 1'b1;
    end
  end

  assign bus.dataOut      = dataOutQ;
  assign bus.ioOutValid   = !outEmpty;
  assign bus.ioOutData    = outEmpty ? 8'h00 : outMem[outRdPtr];
  assign bus.ioInReady    = !inFull;
  assign bus.ioBufferFull = outCount >= CNT_ALMOST;
  assign bus.simEnd       = simEndQ;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomized bench for mem_io_responder against a queue-based reference model.
module tb_mem_io_responder;
  logic clkIn = 1'b0;
  logic resetIn;
  int   checks = 0;
  int   errors = 0;

  always #5 clkIn = ~clkIn;

  mem_io_responder_if bus();

  mem_io_responder #(.RAM_ADDR_WIDTH(17), .FIFO_DEPTH_LOG(3)) dut (
    .clkIn(clkIn),
    .resetIn(resetIn),
    .bus(bus)
  );

  // Reference model: byte store, two 8-deep byte queues, end flags.
  logic [7:0] mRam [int];
  logic [7:0] mOutQ [$];
  logic [7:0] mInQ [$];
  bit         mEndReq, mSimEnd, mDataKnown;
  logic [7:0] mData;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic modelEdge(input bit rw, input logic [31:0] a, input logic [7:0] d,
                           input bit oRdy, input bit iV, input logic [7:0] iD, input bit rst);
    int oc, ic, idx;
    bit endPrev, oPop, oPush, outFullNow, inNonEmptyNow;
    if (rst) begin
      mOutQ.delete();
      mInQ.delete();
      mEndReq = 0;
      mSimEnd = 0;
      mData = 8'h00;
      mDataKnown = 1;
      return;
    end
    oc = mOutQ.size();
    ic = mInQ.size();
    endPrev = mEndReq;
    oPop = (oc > 0) && oRdy;
    oPush = 0;
    mData = 8'h00;
    mDataKnown = 1;
    if (a[17:16] != 2'b11) begin
      idx = int'(a % 32'h0002_0000);
      if (rw) mRam[idx] = d;
      else if (mRam.exists(idx)) mData = mRam[idx];
      else mDataKnown = 0;
    end else if (a[2:0] == 3'd0) begin
      if (rw) oPush = (oc < 8) || oPop;
      else if (ic > 0) mData = mInQ.pop_front();
    end else if (a[2:0] == 3'd4) begin
      outFullNow = (oc == 8);
      inNonEmptyNow = (ic > 0);
      if (rw) mEndReq = 1;
      else mData = {6'b0, outFullNow, inNonEmptyNow};
    end
    if (oPop) void'(mOutQ.pop_front());
    if (oPush) mOutQ.push_back(d);
    if (iV && ic < 8) mInQ.push_back(iD);
    if (endPrev && oc == 0) mSimEnd = 1;
  endtask

  task automatic step(input bit rw, input logic [31:0] a, input logic [7:0] d,
                      input bit oRdy, input bit iV, input logic [7:0] iD, input bit rst);
    bus.readWriteIn = rw;
    bus.addrIn      = a;
    bus.dataIn      = d;
    bus.ioOutReady  = oRdy;
    bus.ioInValid   = iV;
    bus.ioInData    = iD;
    resetIn         = rst;
    @(posedge clkIn);
    modelEdge(rw, a, d, oRdy, iV, iD, rst);
    #1;
    if (mDataKnown) chk("dataOut", bus.dataOut, mData);
    chk("ioOutValid", 8'(bus.ioOutValid), 8'(mOutQ.size() > 0));
    if (mOutQ.size() > 0) chk("ioOutData", bus.ioOutData, mOutQ[0]);
    chk("ioInReady", 8'(bus.ioInReady), 8'(mInQ.size() < 8));
    chk("ioBufferFull", 8'(bus.ioBufferFull), 8'(mOutQ.size() >= 6));
    chk("simEnd", 8'(bus.simEnd), 8'(mSimEnd));
  endtask

  initial begin
    logic [31:0] a;
    int r;

    step(0, 32'h0, 8'h00, 0, 0, 8'h00, 1);
    step(0, 32'h0, 8'h00, 0, 0, 8'h00, 1);
    chk("rst_dataOut", bus.dataOut, 8'h00);
    chk("rst_ioOutValid", 8'(bus.ioOutValid), 8'h00);
    chk("rst_ioInReady", 8'(bus.ioInReady), 8'h01);
    chk("rst_ioBufferFull", 8'(bus.ioBufferFull), 8'h00);
    chk("rst_simEnd", 8'(bus.simEnd), 8'h00);

    // RAM round trip, write-then-read, upper-bit aliasing
    step(1, 32'h0, 8'h5A, 0, 0, 8'h00, 0);
    step(1, 32'h10, 8'hA5, 0, 0, 8'h00, 0);
    chk("ram_write_dataOut", bus.dataOut, 8'h00);
    step(1, 32'h11, 8'h3C, 0, 0, 8'h00, 0);
    step(0, 32'h10, 8'h00, 0, 0, 8'h00, 0);
    chk("rt_first", bus.dataOut, 8'hA5);
    step(0, 32'h11, 8'h00, 0, 0, 8'h00, 0);
    chk("rt_second", bus.dataOut, 8'h3C);
    step(1, 32'h12, 8'h99, 0, 0, 8'h00, 0);
    step(0, 32'h12, 8'h00, 0, 0, 8'h00, 0);
    chk("wr_then_rd", bus.dataOut, 8'h99);
    step(0, 32'hFFFC_0010, 8'h00, 0, 0, 8'h00, 0);
    chk("alias_upper", bus.dataOut, 8'hA5);

    // Idle parking with one host byte queued
    step(0, 32'h0, 8'h00, 0, 1, 8'h77, 0);
    repeat (10) begin
      step(0, 32'h0, 8'h00, 0, 0, 8'h00, 0);
      chk("park_data", bus.dataOut, 8'h5A);
    end
    step(0, 32'h30004, 8'h00, 0, 0, 8'h00, 0);
    chk("park_status", bus.dataOut, 8'h01);
    step(0, 32'h30000, 8'h00, 0, 0, 8'h00, 0);
    chk("park_pop", bus.dataOut, 8'h77);
    step(0, 32'h30000, 8'h00, 0, 0, 8'h00, 0);
    chk("empty_pop", bus.dataOut, 8'h00);

    // Output backpressure and drain order
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h30000, 8'(8'h41 + i), 0, 0, 8'h00, 0);
      if (i == 4) chk("bf_after5", 8'(bus.ioBufferFull), 8'h00);
      if (i == 5) chk("bf_after6", 8'(bus.ioBufferFull), 8'h01);
    end
    step(0, 32'h30004, 8'h00, 0, 0, 8'h00, 0);
    chk("status_outFull", bus.dataOut, 8'h02);
    step(1, 32'h30000, 8'h49, 0, 0, 8'h00, 0);
    chk("head_hold", bus.ioOutData, 8'h41);
    for (int i = 0; i < 8; i++) begin
      step(0, 32'h0, 8'h00, 1, 0, 8'h00, 0);
      if (i < 7) chk("drain_order", bus.ioOutData, 8'(8'h42 + i));
    end
    chk("drained_valid", 8'(bus.ioOutValid), 8'h00);

    // Input streaming across pointer wrap
    for (int i = 0; i < 20; i++) begin
      step(0, 32'h30000, 8'h00, 0, 1, 8'(i), 0);
      chk("in_stream", bus.dataOut, (i == 0) ? 8'h00 : 8'(i - 1));
    end
    step(0, 32'h30000, 8'h00, 0, 0, 8'h00, 0);
    chk("in_last", bus.dataOut, 8'h13);

    // Randomized traffic
    repeat (400) begin
      r = int'($urandom_range(0, 99));
      a = $urandom & 32'hFFFC_0000;
      if (r < 45)      a = a | ($urandom_range(0, 1) != 0 ? 32'h1_0000 : 32'h0) | 32'($urandom_range(0, 15));
      else if (r < 75) a = a | 32'h3_0000;
      else if (r < 90) a = a | 32'h3_0000 | 32'($urandom_range(1, 7));
      else             a = 32'h0;
      step($urandom_range(0, 1) != 0, a, 8'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 59) == 0);
    end

    // End of program
    step(0, 32'h0, 8'h00, 0, 0, 8'h00, 1);
    step(1, 32'h30000, 8'hD1, 0, 0, 8'h00, 0);
    step(1, 32'h30000, 8'hD2, 0, 0, 8'h00, 0);
    step(1, 32'h30000, 8'hD3, 0, 0, 8'h00, 0);
    step(1, 32'h30004, 8'hFF, 0, 0, 8'h00, 0);
    repeat (3) step(0, 32'h0, 8'h00, 0, 0, 8'h00, 0);
    chk("end_hold", 8'(bus.simEnd), 8'h00);
    repeat (3) step(0, 32'h0, 8'h00, 1, 0, 8'h00, 0);
    chk("end_empty_cycle", 8'(bus.simEnd), 8'h00);
    step(0, 32'h0, 8'h00, 1, 0, 8'h00, 0);
    chk("end_rise", 8'(bus.simEnd), 8'h01);
    repeat (5) step(0, 32'h0, 8'h00, 0, 0, 8'h00, 0);
    chk("end_sticky", 8'(bus.simEnd), 8'h01);

    // Reset during an I/O write with the output FIFO draining
    step(1, 32'h30000, 8'hB1, 0, 0, 8'h00, 0);
    step(1, 32'h30000, 8'hB2, 0, 0, 8'h00, 0);
    step(1, 32'h30000, 8'hEE, 1, 0, 8'h00, 1);
    chk("mid_rst_valid", 8'(bus.ioOutValid), 8'h00);
    chk("mid_rst_bf", 8'(bus.ioBufferFull), 8'h00);
    chk("mid_rst_simEnd", 8'(bus.simEnd), 8'h00);
    chk("mid_rst_dataOut", bus.dataOut, 8'h00);
    repeat (4) step(0, 32'h0, 8'h00, 1, 0, 8'h00, 0);
    chk("no_ghost_byte", 8'(bus.ioOutValid), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
